// File: rtl/spi_bridge_pkg.sv
// Shared widths, slave-select idle pattern and FSM state encoding for the SPI shift engine.
package spi_bridge_pkg;

  localparam int SPI_DATA_W     = 8;
  localparam int SPI_NUM_SLAVES = 8;
  localparam logic [SPI_NUM_SLAVES-1:0] SS_NONE = 8'hFF;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DONE  = 2'd3
  } spi_state_e;

endpackage

// File: rtl/spi_clk_div.sv
// Free-running bit-clock divider: SPICLK toggles every CLK_DIV ACLK cycles, with rise/fall ticks.
module spi_clk_div #(
  parameter int CLK_DIV = 2
) (
  input  logic ACLK,
  input  logic ARESETN,
  output logic SPICLK,
  output logic rise_tick,
  output logic fall_tick
);

  logic [7:0] div_cnt;
  logic       terminal;

  // Ticks are asserted in the cycle whose closing edge flips SPICLK.
  assign terminal  = (div_cnt == 8'(CLK_DIV - 1));
  assign rise_tick = terminal && !SPICLK;
  assign fall_tick = terminal && SPICLK;

  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      div_cnt <= '0;
      SPICLK  <= 1'b0;
    end else if (terminal) begin
      div_cnt <= '0;
      SPICLK  <= ~SPICLK;
    end else begin
      div_cnt <= div_cnt + 8'd1;
    end
  end

endmodule

// File: rtl/spi_shift_engine.sv
// Mode-0 SPI byte shifter driven by a free-running SPICLK reference.
// Define SPI_LOOPBACK_EN to sample the engine's own MOSI instead of the MISO pin.
module spi_shift_engine
  import spi_bridge_pkg::*;
#(
  parameter int CLK_DIV = 2
) (
  input  logic                      ACLK,
  input  logic                      ARESETN,
  input  logic                      SPI_start,
  input  logic [SPI_NUM_SLAVES-1:0] SPI_select,
  input  logic [SPI_DATA_W-1:0]     tx_data,
  output logic                      SPI_busy,
  output logic                      SPICLK,
  output logic [SPI_DATA_W-1:0]     rx_data,
  output logic                      rx_valid,
  output logic                      SCLK,
  output logic                      MOSI,
  input  logic                      MISO,
  output logic [SPI_NUM_SLAVES-1:0] SS_n
);

  spi_state_e              state;
  logic                    rise_tick;
  logic                    fall_tick;
  logic                    sample_bit;
  logic [3:0]              bit_cnt;
  logic [SPI_DATA_W-2:0]   tx_sr;
  logic [SPI_DATA_W-1:0]   rx_sr;

  spi_clk_div #(
    .CLK_DIV (CLK_DIV)
  ) u_clk_div (
    .ACLK      (ACLK),
    .ARESETN   (ARESETN),
    .SPICLK    (SPICLK),
    .rise_tick (rise_tick),
    .fall_tick (fall_tick)
  );

`ifdef SPI_LOOPBACK_EN
  logic unused_miso;
  assign unused_miso = MISO;
  assign sample_bit  = MOSI;
`else
  assign sample_bit  = MISO;
`endif

  // Shift registers hold only in-flight data, so they carry no reset.
  always_ff @(posedge ACLK) begin
    if (state == ST_IDLE && rise_tick && SPI_start)
      tx_sr <= tx_data[SPI_DATA_W-2:0];
    else if (state == ST_SHIFT && fall_tick)
      tx_sr <= {tx_sr[SPI_DATA_W-3:0], 1'b0};
    if (state == ST_SHIFT && rise_tick)
      rx_sr <= {rx_sr[SPI_DATA_W-2:0], sample_bit};
  end

  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      state    <= ST_IDLE;
      SCLK     <= 1'b0;
      MOSI     <= 1'b0;
      SS_n     <= SS_NONE;
      SPI_busy <= 1'b0;
      rx_data  <= '0;
      rx_valid <= 1'b0;
      bit_cnt  <= '0;
    end else begin
      rx_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (rise_tick && SPI_start) begin
            state    <= ST_SETUP;
            SS_n     <= SPI_select;
            MOSI     <= tx_data[SPI_DATA_W-1];
            SPI_busy <= 1'b1;
            bit_cnt  <= '0;
          end
        end
        ST_SETUP: begin
          if (fall_tick)
            state <= ST_SHIFT;
        end
        ST_SHIFT: begin
          // SCLK is registered from the same ticks that flip SPICLK, so the two stay aligned.
          if (rise_tick) begin
            SCLK    <= 1'b1;
            bit_cnt <= bit_cnt + 4'd1;
          end else if (fall_tick) begin
            SCLK <= 1'b0;
            if (bit_cnt == 4'd8) begin
              state    <= ST_DONE;
              rx_data  <= rx_sr;
              rx_valid <= 1'b1;
              SS_n     <= SS_NONE;
              SPI_busy <= 1'b0;
              MOSI     <= 1'b0;
            end else begin
              MOSI <= tx_sr[SPI_DATA_W-2];
            end
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/spi_shift_engine.md
SPI_SHIFT_ENGINE -- requirements
Module: spi_shift_engine

Interface
REQ-001 Parameter CLK_DIV, default 2, meaning SPICLK half-period in ACLK cycles; legal range 1..255.
REQ-002 ACLK  input  1  sole clock; all logic on rising edge.
REQ-003 ARESETN  input  1  reset; synchronous, active-low.
REQ-004 SPI_start  input  1  transfer request from the SPI manager; level, held until SPICLK rises.
REQ-005 SPI_select  input  8  slave-select pattern, active-low per bit.
REQ-006 tx_data  input  8  byte to transmit, MSB first.
REQ-007 SPI_busy  output  1  high while a transfer is in progress.
REQ-008 SPICLK  output  1  free-running bit-clock reference, 50% duty.
REQ-009 rx_data  output  8  last received byte.
REQ-010 rx_valid  output  1  one-cycle pulse when rx_data updates.
REQ-011 SCLK  output  1  pad serial clock, mode 0, idles low.
REQ-012 MOSI  output  1  pad serial data out.
REQ-013 MISO  input  1  pad serial data in, ACLK-synchronous.
REQ-014 SS_n  output  8  pad slave selects; bit i follows latched SPI_select bit i.

Function
REQ-015 Divider: count 0..CLK_DIV-1 and toggle SPICLK on terminal count, giving rise and fall ticks.
REQ-016 States: IDLE, SETUP, SHIFT, DONE; no other encodings are reachable.
REQ-017 IDLE->SETUP: on a rise tick with SPI_start=1. Latch tx_data and SPI_select, drive SS_n=latched select, drive MOSI=tx_data[7], and set SPI_busy=1, all in the same cycle that SPICLK goes high.
REQ-018 SETUP->SHIFT: on the next fall tick; SCLK stays low through SETUP.
REQ-019 SHIFT: SCLK mirrors SPICLK.
REQ-020 SHIFT, rise ticks: sample MISO into shift-register LSB and increment bit count.
REQ-021 SHIFT, fall ticks 1..7: shift MOSI to the next bit.
REQ-022 SHIFT->DONE: on the fall tick after the 8th sample; SCLK returns low.
REQ-023 DONE: for one cycle, update rx_data, pulse rx_valid, drive SS_n=8'hFF and SPI_busy=0, MOSI=0; then go to IDLE.
REQ-024 SPI_busy stays high for exactly 17*CLK_DIV ACLK cycles per transfer.
REQ-025 SPI_start while not IDLE is ignored; no queueing.
REQ-026 SPI_start still high at a rise tick in IDLE after DONE starts a new transfer.
REQ-027 SPI_select=8'hFF or multi-zero patterns are driven onto SS_n unmodified; the transfer still runs.
REQ-028 tx_data and SPI_select changes after acceptance do not affect the transfer in flight.
REQ-029 rx_data holds its value until the next DONE.

Reset
REQ-030 ARESETN=0 at any ACLK edge, including mid-transfer, aborts the transfer.
REQ-031 Reset values: state=IDLE, divider=0, SPICLK=0, SCLK=0, MOSI=0, SS_n=8'hFF, SPI_busy=0, rx_data=8'h00, rx_valid=0.
REQ-032 Reset produces no rx_valid pulse and no partial-byte update.

Configuration
REQ-033 SPI_LOOPBACK_EN defined: the internal sample source is MOSI and the MISO pin is ignored.
REQ-034 SPI_LOOPBACK_EN undefined: the sample source is MISO and behaviour is otherwise identical.

Structure
REQ-035 Package spi_bridge_pkg holds the state encoding, SPI_DATA_W=8, SPI_NUM_SLAVES=8 and SS_NONE=8'hFF.
REQ-036 Sub-module spi_clk_div holds the divider, SPICLK and the rise/fall ticks.

Verification
REQ-037 CLK_DIV=2, tx_data=8'hA5, select=8'h7F, MISO driven 8'h3C -> MOSI shows 10100101, SS_n=8'h7F, rx_data=8'h3C, rx_valid is one pulse, SPI_busy high 34 cycles.
REQ-038 SPI_LOOPBACK_EN, CLK_DIV=1, tx_data=8'hC3 -> rx_data=8'hC3, SPI_busy high 17 cycles.
REQ-039 SPI_start held high through two transfers (8'h01, then 8'h80 presented after DONE) -> two back-to-back transfers, two rx_valid pulses, SS_n=8'hFF between them.
REQ-040 ARESETN=0 after 4th SCLK rise -> next cycle SS_n=8'hFF, SCLK=0, SPI_busy=0, rx_data=8'h00, no rx_valid.
REQ-041 SPI_start pulsed while busy, tx_data changed mid-transfer -> the original byte completes and no second transfer starts.
